// File: rtl/gsim_operand_sched.sv
// Gauss-Seidel operand sequencer: loads b, holds x (16.16), issues one row per PE_LAT cycles,
// writes PE results back and streams x out. Optional early exit under GSIM_CONV_CHECK_EN.
module gsim_operand_sched #(
  parameter int unsigned N      = 16,
  parameter int unsigned ITER   = 100,
  parameter int unsigned PE_LAT = 3
`ifdef GSIM_CONV_CHECK_EN
  ,
  parameter logic [31:0] CONV_THR = 32'h0000_0010
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_en,
  input  logic [15:0] b_in,
  output logic [31:0] pe_in_1,
  output logic [31:0] pe_in_2,
  output logic [31:0] pe_in_3,
  output logic [31:0] pe_in_4,
  output logic [31:0] pe_in_5,
  output logic [31:0] pe_in_6,
  output logic [15:0] pe_b,
  input  logic [31:0] pe_out,
  output logic        busy,
  output logic        out_valid,
  output logic [31:0] x_out,
  output logic        done
`ifdef GSIM_CONV_CHECK_EN
  ,
  output logic        conv_early
`endif
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned SW = $clog2(ITER + 1);
  localparam int unsigned WW = (PE_LAT > 2) ? $clog2(PE_LAT - 1) : 1;
  localparam int Offs [6] = '{-3, 3, -2, 2, -1, 1};

  typedef enum logic [2:0] {StIdle, StLoad, StIssue, StWait, StWb, StOut} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   load_cnt_q, load_cnt_d, row_q, row_d, out_cnt_q, out_cnt_d;
  logic [SW-1:0]   sweep_q, sweep_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic [31:0]     x_q [N];
  logic [31:0]     x_d [N];
  logic [15:0]     b_q [N];
  logic [15:0]     b_d [N];
  logic [31:0]     pe_op_q [6];
  logic [31:0]     pe_op_d [6];
  logic [15:0]     pe_b_q, pe_b_d;
  logic            busy_q, busy_d, out_valid_q, out_valid_d, done_q, done_d;
  logic [31:0]     x_out_q, x_out_d;
  logic            early;
  int              idx;
`ifdef GSIM_CONV_CHECK_EN
  logic [32:0]     max_d_q, max_d_d, abs_d, max_new;
  logic signed [32:0] diff;
  logic            conv_q, conv_d;
`endif

  always_comb begin
    state_d     = state_q;
    load_cnt_d  = load_cnt_q;
    row_d       = row_q;
    sweep_d     = sweep_q;
    wait_d      = wait_q;
    out_cnt_d   = out_cnt_q;
    x_d         = x_q;
    b_d         = b_q;
    pe_op_d     = pe_op_q;
    pe_b_d      = pe_b_q;
    busy_d      = busy_q;
    out_valid_d = out_valid_q;
    x_out_d     = x_out_q;
    done_d      = 1'b0;
    early       = 1'b0;
    idx         = 0;
`ifdef GSIM_CONV_CHECK_EN
    max_d_d = max_d_q;
    conv_d  = conv_q;
    diff    = $signed({pe_out[31], pe_out}) - $signed({x_q[row_q][31], x_q[row_q]});
    abs_d   = diff[32] ? 33'(-diff) : 33'(diff);
    max_new = (abs_d > max_d_q) ? abs_d : max_d_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (in_en) begin
          b_d[0]     = b_in;
          load_cnt_d = IW'(1);
          busy_d     = 1'b1;
          for (int i = 0; i < int'(N); i++) x_d[i] = '0;
`ifdef GSIM_CONV_CHECK_EN
          max_d_d = '0;
          conv_d  = 1'b0;
`endif
          state_d    = StLoad;
        end
      end
      StLoad: begin
        if (in_en) begin
          b_d[load_cnt_q] = b_in;
          if (load_cnt_q == IW'(N - 1)) begin
            load_cnt_d = '0;
            row_d      = '0;
            sweep_d    = '0;
            state_d    = StIssue;
          end else begin
            load_cnt_d = load_cnt_q + IW'(1);
          end
        end
      end
      StIssue: begin
        wait_d  = '0;
        state_d = (PE_LAT > 2) ? StWait : StWb;
      end
      StWait: begin
        if (wait_q == WW'(PE_LAT - 3)) state_d = StWb;
        else wait_d = wait_q + WW'(1);
      end
      StWb: begin
        x_d[row_q] = pe_out;
`ifdef GSIM_CONV_CHECK_EN
        max_d_d = max_new;
`endif
        if (row_q != IW'(N - 1)) begin
          row_d   = row_q + IW'(1);
          state_d = StIssue;
        end else begin
          row_d   = '0;
          sweep_d = sweep_q + SW'(1);
`ifdef GSIM_CONV_CHECK_EN
          max_d_d = '0;
          early   = (sweep_q != '0) && (max_new < {1'b0, CONV_THR});
          conv_d  = early;
`endif
          if (sweep_d == SW'(ITER) || early) begin
            out_cnt_d   = '0;
            out_valid_d = 1'b1;
            x_out_d     = x_d[0];
            state_d     = StOut;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StOut: begin
        if (out_cnt_q == IW'(N - 1)) begin
          out_valid_d = 1'b0;
          x_out_d     = '0;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          state_d     = StIdle;
        end else begin
          out_cnt_d = out_cnt_q + IW'(1);
          x_out_d   = x_q[out_cnt_d];
        end
      end
      default: state_d = StIdle;
    endcase

    // Operands come from x_d so the row just written back is seen by the next issue.
    if (state_d == StIssue) begin
      for (int k = 0; k < 6; k++) begin
        idx        = int'(row_d) + Offs[k];
        pe_op_d[k] = (idx >= 0 && idx < int'(N)) ? x_d[idx[IW-1:0]] : '0;
      end
      pe_b_d = b_d[row_d];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      load_cnt_q  <= '0;
      row_q       <= '0;
      sweep_q     <= '0;
      wait_q      <= '0;
      out_cnt_q   <= '0;
      for (int i = 0; i < int'(N); i++) begin
        x_q[i] <= '0;
        b_q[i] <= '0;
      end
      for (int k = 0; k < 6; k++) pe_op_q[k] <= '0;
      pe_b_q      <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      x_out_q     <= '0;
      done_q      <= 1'b0;
`ifdef GSIM_CONV_CHECK_EN
      max_d_q     <= '0;
      conv_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      load_cnt_q  <= load_cnt_d;
      row_q       <= row_d;
      sweep_q     <= sweep_d;
      wait_q      <= wait_d;
      out_cnt_q   <= out_cnt_d;
      x_q         <= x_d;
      b_q         <= b_d;
      pe_op_q     <= pe_op_d;
      pe_b_q      <= pe_b_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      x_out_q     <= x_out_d;
      done_q      <= done_d;
`ifdef GSIM_CONV_CHECK_EN
      max_d_q     <= max_d_d;
      conv_q      <= conv_d;
`endif
    end
  end

  assign pe_in_1   = pe_op_q[0];
  assign pe_in_2   = pe_op_q[1];
  assign pe_in_3   = pe_op_q[2];
  assign pe_in_4   = pe_op_q[3];
  assign pe_in_5   = pe_op_q[4];
  assign pe_in_6   = pe_op_q[5];
  assign pe_b      = pe_b_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign x_out     = x_out_q;
  assign done      = done_q;
`ifdef GSIM_CONV_CHECK_EN
  assign conv_early = conv_q;
`endif

endmodule
